fp_mult_arbiter: RTL and testbench
==================================

Name: fp_mult_arbiter

Overview:
- Shares one external 4-stage pipelined fp32 multiplier among NUM_REQ requesters, e.g. systolic PE rows or the scale/normalise unit.
- Round-robin arbitration issues at most one operand pair per cycle into the multiplier.
- A tag pipeline matched to the multiplier latency tracks the owner of each operation.
- Each result is returned to its owner through a per-requester valid/ready response register.
- The multiplier has no stall input, so response space is reserved before issue.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MULT_LATENCY, 4, clock edges from the multiplier sampling a/b to result updating.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_a  in  NUM_REQ*32  operand A, requester i in bits [32i+31:32i].
- req_b  in  NUM_REQ*32  operand B, same packing.
- req_ready  out  NUM_REQ  one-hot grant; a handshake occurs when req_valid[i] and req_ready[i] are both high.
- rsp_valid  out  NUM_REQ  result held for requester i.
- rsp_data  out  NUM_REQ*32  per-requester fp32 result.
- rsp_ready  in  NUM_REQ  requester i consumes its result.
- mult_a  out  32  registered operand A to the multiplier.
- mult_b  out  32  registered operand B to the multiplier.
- mult_result  in  32  multiplier result.
- busy  out  1  any operation in flight or any response held.

Behaviour:
- Reset (async, rst low): mult_a, mult_b, rsp_data = 0; rsp_valid = 0; all tag valids = 0; inflight = 0; rr_ptr = 0; busy = 0.
- req_ready is combinational and 0 while rst is low.
- Reset mid-operation drops all in-flight ops silently. The multiplier shares rst.
- pending[i] = inflight[i] | rsp_valid[i]. At most one outstanding op per requester, counting the held response.
- eligible[i] = req_valid[i] & ~pending[i].
- Grant: first eligible index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ. req_ready is one-hot or zero and depends only on req_valid and registered state.
- Accept at edge T:
  - mult_a/mult_b <= req_a/req_b of the granted requester.
  - tag[0] <= {valid=1, id}.
  - inflight[id] <= 1.
  - rr_ptr <= id+1, wrapping to 0 after NUM_REQ-1.
- No accept: tag[0].valid <= 0; mult_a/mult_b hold their values; rr_ptr holds.
- Tag pipeline has MULT_LATENCY+1 entries (indices 0..MULT_LATENCY) and shifts every edge.
  - The multiplier samples mult_a/b at edge T+1; mult_result is valid after edge T+MULT_LATENCY.
  - tag[MULT_LATENCY] aligns with that result.
- Capture, when tag[MULT_LATENCY].valid at edge T+MULT_LATENCY+1:
  - rsp_data[id] <= mult_result; rsp_valid[id] <= 1; inflight[id] <= 0.
  - Accept-to-rsp_valid latency is 5 edges with default parameters.
- rsp_valid[i] clears on the edge where rsp_ready[i] is high; rsp_data[i] holds its value.
  - The requester becomes eligible in the following cycle; there is no same-cycle bypass.
  - Per-requester throughput is 1 op per 7 cycles. Aggregate throughput is up to 1 op per cycle when at least 7 requesters are active.
- Capture never conflicts with a held response, because issue requires ~pending.
- Simultaneous capture for requester i and pop for requester j≠i are independent.
- No arithmetic in this block. Zero, overflow and underflow handling belong to the multiplier; results pass through unmodified.
- busy = OR(tag valids) | OR(inflight) | OR(rsp_valid).

Decomposition:
- Package fp_mult_arb_pkg:
  - FP_W = 32.
  - ID_W = $clog2(NUM_REQ) via a function.
  - Packed struct mult_tag_t {logic valid; logic [ID_W-1:0] id}.
- Sub-module rr_arbiter:
  - Inputs: eligible vector, rr_ptr.
  - Outputs: one-hot grant, encoded id, any_grant.
  - Purely combinational; reused by later shared-resource schedulers.
- The multiplier is instantiated by the parent, not inside this block.

Test Plan:
- Single op: req0 a=0x40000000, b=0x40400000 accepted at edge T → rsp_valid[0] rises at edge T+5, rsp_data[0]=0x40C00000; busy falls after rsp_ready pops it.
- Round-robin: all four requesters valid from reset with a=0x3FC00000, b=0x3FC00000 → grants at consecutive edges to 0,1,2,3; each rsp_data=0x40100000 in the same order; no second grant to requester 0 before its response is popped.
- Backpressure: req1 completes 0x40000000*0xC0400000 with rsp_ready[1]=0 for 10 cycles → rsp_data[1]=0xC0C00000 held stable; req_ready[1]=0 throughout despite req_valid[1]=1; granted the cycle after the pop.
- Zero operand: req2 a=0x00000000, b=0x40A00000 → rsp_data[2]=0x00000000, routed only to requester 2.
- Pointer wrap: rr_ptr=3 with req0 and req3 valid → grant 3, then 0 on the next eligible cycle.
- Reset mid-flight: assert rst low 2 cycles after accepting ops from req0 and req1 → all outputs zero immediately, no rsp_valid after release, both requesters grantable on the first cycle after release.

Source files
------------

// File: rtl/fp_mult_arb_pkg.sv
// Shared types and constants for the fp32 multiplier arbiter and its helpers.
package fp_mult_arb_pkg;

    localparam int unsigned FP_W    = 32;
    localparam int unsigned MAX_REQ = 8;

    // Number of bits needed to encode n distinct ids, never less than one.
    function automatic int unsigned id_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w = w + 1;
        return w;
    endfunction

    // Ids are sized for the largest supported requester count so the tag type
    // does not depend on the instance parameters.
    localparam int unsigned ID_W = id_width(MAX_REQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } mult_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first eligible index at or
// after ptr, wrapping modulo N.
module rr_arbiter
    import fp_mult_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]    eligible,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] id,
    output logic            any_grant
);

    // Walk offsets from ptr; the first eligible hit wins.
    always_comb begin
        int unsigned pos;
        grant     = '0;
        id        = '0;
        any_grant = 1'b0;
        pos       = 0;
        for (int unsigned off = 0; off < N; off++) begin
            pos = 32'(ptr) + off;
            if (pos >= N) pos = pos - N;
            for (int unsigned i = 0; i < N; i++) begin
                if (!any_grant && eligible[i] && (pos == i)) begin
                    grant[i]  = 1'b1;
                    id        = ID_W'(i);
                    any_grant = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one pipelined fp32 multiplier among NUM_REQ requesters. A tag pipe
// matched to the multiplier latency routes each result back to its owner.
module fp_mult_arbiter
    import fp_mult_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned MULT_LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*FP_W-1:0] req_a,
    input  logic [NUM_REQ*FP_W-1:0] req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [NUM_REQ*FP_W-1:0] rsp_data,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [FP_W-1:0]         mult_a,
    output logic [FP_W-1:0]         mult_b,
    input  logic [FP_W-1:0]         mult_result,
    output logic                    busy
);

    logic [NUM_REQ-1:0] inflight;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    gnt_id;
    logic               any_grant;
    logic               accept;
    logic [FP_W-1:0]    sel_a;
    logic [FP_W-1:0]    sel_b;
    logic               tag_any;
    mult_tag_t          tags [MULT_LATENCY+1];

    // A held response counts as outstanding, so capture can never collide with it.
    assign pending  = inflight | rsp_valid;
    assign eligible = req_valid & ~pending;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .eligible  (eligible),
        .ptr       (rr_ptr),
        .grant     (grant),
        .id        (gnt_id),
        .any_grant (any_grant)
    );

    assign req_ready = grant & {NUM_REQ{rst}};
    assign accept    = any_grant & rst;

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*FP_W +: FP_W];
                sel_b = req_b[i*FP_W +: FP_W];
            end
        end
    end

    // Operand registers feeding the multiplier; hold when nothing is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mult_a <= '0;
            mult_b <= '0;
        end else if (accept) begin
            mult_a <= sel_a;
            mult_b <= sel_b;
        end
    end

    // Round-robin pointer moves just past the last winner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        end
    end

    // Tag pipe shifts every edge; the last entry lines up with mult_result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k <= MULT_LATENCY; k++) tags[k] <= '0;
        end else begin
            tags[0] <= '{valid: accept, id: gnt_id};
            for (int k = 1; k <= MULT_LATENCY; k++) tags[k] <= tags[k-1];
        end
    end

    // Per-requester in-flight flag and valid/ready response register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight  <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (tags[MULT_LATENCY].valid && (tags[MULT_LATENCY].id == ID_W'(i))) begin
                    rsp_data[i*FP_W +: FP_W] <= mult_result;
                    rsp_valid[i]             <= 1'b1;
                    inflight[i]              <= 1'b0;
                end else begin
                    if (rsp_ready[i]) rsp_valid[i] <= 1'b0;
                    if (accept && grant[i]) inflight[i] <= 1'b1;
                end
            end
        end
    end

    // Busy while any tag, in-flight op or held response remains.
    always_comb begin
        tag_any = 1'b0;
        for (int k = 0; k <= MULT_LATENCY; k++) tag_any = tag_any | tags[k].valid;
        busy = tag_any | (|inflight) | (|rsp_valid);
    end

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Scoreboard bench for fp_mult_arbiter with a behavioural 4-stage fp32 multiplier.
module tb_fp_mult_arbiter;

    localparam int NR  = 4;
    localparam int LAT = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*32-1:0] req_a = '0;
    logic [NR*32-1:0] req_b = '0;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    rsp_valid;
    logic [NR*32-1:0] rsp_data;
    logic [NR-1:0]    rsp_ready = '0;
    logic [31:0]      mult_a;
    logic [31:0]      mult_b;
    logic [31:0]      mult_result;
    logic             busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Stimulus controls.
    logic [NR-1:0] en       = '0;
    logic [NR-1:0] hold     = '1;
    logic          rand_rdy = 1'b0;
    logic          use_rand = 1'b0;
    logic [NR-1:0] last_hs  = '0;

    fp_mult_arbiter #(
        .NUM_REQ      (NR),
        .MULT_LATENCY (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_ready   (rsp_ready),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .mult_result (mult_result),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Truncating fp32 multiply for normals and zeros.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        logic [22:0] m;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            e = e + 1;
            m = p[46:24];
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {s, 8'hff, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], m};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 9) == 0) r[30:0] = '0;
        else r[30:23] = 8'($urandom_range(100, 154));
        return r;
    endfunction

    // External multiplier: samples a/b one edge after issue, result after four.
    logic [31:0] mstage [4];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) mstage[k] <= '0;
        end else begin
            mstage[0] <= fmul(mult_a, mult_b);
            for (int k = 1; k < 4; k++) mstage[k] <= mstage[k-1];
        end
    end
    assign mult_result = mstage[3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard of issued operations.
    typedef struct {
        int          id;
        logic [31:0] data;
        int          acc;
    } exp_t;
    exp_t sb[$];

    logic [NR-1:0]   pend_m  = '0;
    int              ptr_m   = 0;
    logic [63:0]     ops_m   = '0;
    logic [NR-1:0]   prev_v  = '0;
    logic [NR-1:0]   elig_m;
    logic [2*NR-1:0] rot;
    logic [NR-1:0]   exp_rdy;
    logic            found;
    int              k;

    // Monitor: checks grant, busy, operand regs and responses against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("rst_req_ready", 64'(req_ready), 64'd0);
            check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_mult_ops", {mult_a, mult_b}, 64'd0);
            check("rst_rsp_data", 64'(|rsp_data), 64'd0);
            sb.delete();
            pend_m = '0;
            ptr_m  = 0;
            ops_m  = '0;
            prev_v = '0;
        end else begin
            elig_m  = req_valid & ~pend_m;
            rot     = {elig_m, elig_m} >> ptr_m;
            exp_rdy = '0;
            found   = 1'b0;
            for (int p = 0; p < NR; p++) begin
                if (!found && rot[p]) begin
                    exp_rdy = NR'(1) << ((ptr_m + p) % NR);
                    found   = 1'b1;
                end
            end
            check("req_ready", 64'(req_ready), 64'(exp_rdy));
            check("busy", 64'(busy), 64'(|pend_m));
            check("mult_ops", {mult_a, mult_b}, ops_m);

            for (int i = 0; i < NR; i++) begin
                if (rsp_valid[i]) begin
                    k = -1;
                    foreach (sb[j]) if (sb[j].id == i) k = j;
                    if (k < 0) begin
                        check("rsp_unexpected", 64'(rsp_valid[i]), 64'd0);
                    end else begin
                        check("rsp_data", 64'(rsp_data[i*32 +: 32]), 64'(sb[k].data));
                        if (!prev_v[i]) check("rsp_latency", 64'(cyc - sb[k].acc), 64'(LAT));
                        if (rsp_ready[i]) begin
                            pend_m[i] = 1'b0;
                            sb.delete(k);
                        end
                    end
                end
            end

            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back('{id: i,
                                   data: fmul(req_a[i*32 +: 32], req_b[i*32 +: 32]),
                                   acc: cyc + 1});
                    pend_m[i] = 1'b1;
                    ptr_m     = (i + 1) % NR;
                    ops_m     = {req_a[i*32 +: 32], req_b[i*32 +: 32]};
                end
            end
            prev_v = rsp_valid;
        end
    end

    // One clock of stimulus; last_hs records the handshakes taken at this edge.
    task automatic step();
        @(negedge clk);
        last_hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (last_hs[i] || !req_valid[i]) begin
                req_valid[i] = en[i];
                if (en[i] && use_rand) begin
                    req_a[i*32 +: 32] = rand_fp();
                    req_b[i*32 +: 32] = rand_fp();
                end
            end
            rsp_ready[i] = hold[i] ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_valid[i]      = 1'b1;
    endtask

    task automatic wait_rsp(input int i, input string name);
        int n;
        n = 0;
        while (!rsp_valid[i] && n < 30) begin
            step();
            n++;
        end
        check(name, 64'(rsp_valid[i]), 64'd1);
    endtask

    task automatic drain();
        int n;
        req_valid = '0;
        en        = '0;
        hold      = '0;
        rand_rdy  = 1'b0;
        use_rand  = 1'b0;
        n         = 0;
        step();
        while (busy && n < 60) begin
            step();
            n++;
        end
        check("drain_busy", 64'(busy), 64'd0);
        check("drain_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        do_reset();

        // Single op from requester 0.
        hold = '1;
        set_req(0, 32'h4000_0000, 32'h4040_0000);
        step();
        check("single_grant", 64'(last_hs), 64'h1);
        wait_rsp(0, "single_rsp_valid");
        check("single_rsp_data", 64'(rsp_data[31:0]), 64'h40C0_0000);
        hold[0] = 1'b0;
        step();
        step();
        check("single_popped", 64'(rsp_valid[0]), 64'd0);
        check("single_busy_low", 64'(busy), 64'd0);

        // Round-robin from reset with all requesters asking and responses held.
        do_reset();
        hold = '1;
        en   = '1;
        for (int i = 0; i < NR; i++) set_req(i, 32'h3FC0_0000, 32'h3FC0_0000);
        for (int g = 0; g < NR; g++) begin
            step();
            check("rr_grant", 64'(last_hs), 64'(NR'(1) << g));
        end
        for (int c = 0; c < 8; c++) begin
            step();
            check("rr_no_regrant", 64'(last_hs), 64'd0);
        end
        check("rr_rsp_valid", 64'(rsp_valid), 64'hF);
        for (int i = 0; i < NR; i++) check("rr_rsp_data", 64'(rsp_data[i*32 +: 32]), 64'h4010_0000);
        drain();

        // Backpressure on requester 1.
        hold = 4'b0010;
        en   = 4'b0010;
        set_req(1, 32'h4000_0000, 32'hC040_0000);
        wait_rsp(1, "bp_rsp_valid");
        for (int c = 0; c < 10; c++) begin
            step();
            check("bp_hold_data", 64'(rsp_data[63:32]), 64'hC0C0_0000);
            check("bp_no_ready", 64'(req_ready[1]), 64'd0);
        end
        hold[1] = 1'b0;
        step();
        step();
        step();
        check("bp_regrant", 64'(last_hs[1]), 64'd1);
        drain();

        // Zero operand, routed only to requester 2; leaves the pointer at 3.
        hold = '1;
        set_req(2, 32'h0000_0000, 32'h40A0_0000);
        wait_rsp(2, "zero_rsp_valid");
        check("zero_rsp_data", 64'(rsp_data[95:64]), 64'd0);
        check("zero_only_req2", 64'(rsp_valid), 64'h4);
        drain();

        // Pointer wrap: 3 first, then 0.
        hold = '1;
        set_req(0, 32'h3F80_0000, 32'h4000_0000);
        set_req(3, 32'h4040_0000, 32'h4040_0000);
        step();
        check("wrap_grant3", 64'(last_hs), 64'h8);
        step();
        check("wrap_grant0", 64'(last_hs), 64'h1);
        drain();

        // Reset while ops from requesters 0 and 1 are in flight.
        hold = '1;
        set_req(0, 32'h4000_0000, 32'h4000_0000);
        set_req(1, 32'h4040_0000, 32'h4000_0000);
        step();
        step();
        step();
        step();
        req_valid = 4'b0011;
        rst = 1'b0;
        #1;
        check("mid_rst_ops", {mult_a, mult_b}, 64'd0);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        check("post_rst_grant0", 64'(last_hs), 64'h1);
        step();
        check("post_rst_grant1", 64'(last_hs), 64'h2);
        for (int c = 0; c < 8; c++) step();
        check("post_rst_rsp_valid", 64'(rsp_valid), 64'h3);
        drain();

        // Randomized traffic with random response backpressure.
        use_rand = 1'b1;
        rand_rdy = 1'b1;
        hold     = '0;
        en       = '1;
        repeat (400) step();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
